alu_8: RTL and testbench

//   8-bit SM83 (Game Boy CPU) ALU: arithmetic, logic, rotate/shift, swap and bit ops on A/B.

---
 rtl/alu_8_if.sv | 30 +++
 rtl/alu_8.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_8.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_8_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_8_if
// Description : Operand/result bundle between the CPU sequencer and the
//               8-bit SM83 ALU.
//               master = sequencer side (drives operands, reads results)
//               slave  = ALU side (reads operands, drives results)
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_8_if;
  logic [7:0] regA;      // operand A (accumulator / shift-rotate source)
  logic [7:0] regB;      // operand B; bit ops use regB[2:0] as index
  logic [4:0] opcode;    // operation select
  logic       carryIn;   // current C flag
  logic       flagsWe;   // load flagsQ on the next clock edge
  logic [7:0] res;       // result
  logic [7:0] flagsOut;  // {Z,N,H,C,4'b0000}
  logic [7:0] flagsQ;    // registered flags shadow

  modport master (
    output regA, regB, opcode, carryIn, flagsWe,
    input  res, flagsOut, flagsQ
  );

  modport slave (
    input  regA, regB, opcode, carryIn, flagsWe,
    output res, flagsOut, flagsQ
  );
endinterface
`default_nettype wire

// File: rtl/alu_8.sv
`default_nettype none
// ============================================================================
// Module      : alu_8
// Description : 8-bit SM83 (Game Boy CPU) ALU. Arithmetic, logic,
//               rotate/shift, swap and bit operations on A/B with a
//               registered flags shadow (flagsQ).
//               Optional macro ALU8_OUTREG_EN: registers res/flagsOut
//               (1-cycle latency); flagsQ then loads the registered flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_8 (
  input  wire logic clk,
  input  wire logic reset,
  alu_8_if.slave    bus
);

  localparam logic [4:0] c_op_add  = 5'b00000;
  localparam logic [4:0] c_op_adc  = 5'b00001;
  localparam logic [4:0] c_op_sub  = 5'b00010;
  localparam logic [4:0] c_op_sbc  = 5'b00011;
  localparam logic [4:0] c_op_cp   = 5'b00100;
  localparam logic [4:0] c_op_and  = 5'b00101;
  localparam logic [4:0] c_op_or   = 5'b00110;
  localparam logic [4:0] c_op_xor  = 5'b00111;
  localparam logic [4:0] c_op_rl   = 5'b01000;
  localparam logic [4:0] c_op_rr   = 5'b01001;
  localparam logic [4:0] c_op_rla  = 5'b01010;
  localparam logic [4:0] c_op_rra  = 5'b01011;
  localparam logic [4:0] c_op_rlc  = 5'b01100;
  localparam logic [4:0] c_op_rrc  = 5'b01101;
  localparam logic [4:0] c_op_rlca = 5'b01110;
  localparam logic [4:0] c_op_rrca = 5'b01111;
  localparam logic [4:0] c_op_sla  = 5'b10000;
  localparam logic [4:0] c_op_sra  = 5'b10001;
  localparam logic [4:0] c_op_srl  = 5'b10010;
  localparam logic [4:0] c_op_swap = 5'b10011;
  localparam logic [4:0] c_op_bit  = 5'b10100;
  localparam logic [4:0] c_op_res  = 5'b10101;
  localparam logic [4:0] c_op_set  = 5'b10110;

  logic [7:0] w_a;
  logic [7:0] w_b;
  logic       w_cin;
  logic       w_cin_arith;
  logic [8:0] w_sum;
  logic [4:0] w_sum_lo;
  logic [8:0] w_diff;
  logic [4:0] w_diff_lo;
  logic [7:0] w_mask;
  logic [7:0] w_res;
  logic       w_z_from_res;
  logic       w_z_raw;
  logic       w_z;
  logic       w_n;
  logic       w_h;
  logic       w_c;
  logic [7:0] w_flags;
  logic [7:0] w_flags_src;
  logic [7:0] flags_reg_d;
  logic [7:0] flags_reg_q;

  assign w_a   = bus.regA;
  assign w_b   = bus.regB;
  assign w_cin = bus.carryIn;

  // Shared adder/subtractor; carry-in only participates for ADC/SBC.
  // Bit 4 / bit 8 of the widened results are the half and full carry/borrow.
  always_comb begin
    w_cin_arith = 1'b0;
    if ((bus.opcode == c_op_adc) || (bus.opcode == c_op_sbc)) begin
      w_cin_arith = w_cin;
    end
    w_sum     = {1'b0, w_a} + {1'b0, w_b} + {8'h00, w_cin_arith};
    w_sum_lo  = {1'b0, w_a[3:0]} + {1'b0, w_b[3:0]} + {4'h0, w_cin_arith};
    w_diff    = {1'b0, w_a} - {1'b0, w_b} - {8'h00, w_cin_arith};
    w_diff_lo = {1'b0, w_a[3:0]} - {1'b0, w_b[3:0]} - {4'h0, w_cin_arith};
    w_mask    = 8'h01 << w_b[2:0];
  end

  // Result and flag selection; Z comes from the result unless overridden.
  always_comb begin
    w_res        = w_a;
    w_z_from_res = 1'b1;
    w_z_raw      = 1'b0;
    w_n          = 1'b0;
    w_h          = 1'b0;
    w_c          = w_cin;
    case (bus.opcode)
      c_op_add, c_op_adc: begin
        w_res = w_sum[7:0];
        w_h   = w_sum_lo[4];
        w_c   = w_sum[8];
      end
      c_op_sub, c_op_sbc: begin
        w_res = w_diff[7:0];
        w_n   = 1'b1;
        w_h   = w_diff_lo[4];
        w_c   = w_diff[8];
      end
      c_op_cp: begin
        // A is passed through; flags describe the discarded difference.
        w_res        = w_a;
        w_z_from_res = 1'b0;
        w_z_raw      = (w_diff[7:0] == 8'h00);
        w_n          = 1'b1;
        w_h          = w_diff_lo[4];
        w_c          = w_diff[8];
      end
      c_op_and: begin
        w_res = w_a & w_b;
        w_h   = 1'b1;
        w_c   = 1'b0;
      end
      c_op_or: begin
        w_res = w_a | w_b;
        w_c   = 1'b0;
      end
      c_op_xor: begin
        w_res = w_a ^ w_b;
        w_c   = 1'b0;
      end
      c_op_rl, c_op_rla: begin
        w_res        = {w_a[6:0], w_cin};
        w_c          = w_a[7];
        w_z_from_res = (bus.opcode == c_op_rl);
      end
      c_op_rr, c_op_rra: begin
        w_res        = {w_cin, w_a[7:1]};
        w_c          = w_a[0];
        w_z_from_res = (bus.opcode == c_op_rr);
      end
      c_op_rlc, c_op_rlca: begin
        w_res        = {w_a[6:0], w_a[7]};
        w_c          = w_a[7];
        w_z_from_res = (bus.opcode == c_op_rlc);
      end
      c_op_rrc, c_op_rrca: begin
        w_res        = {w_a[0], w_a[7:1]};
        w_c          = w_a[0];
        w_z_from_res = (bus.opcode == c_op_rrc);
      end
      c_op_sla: begin
        w_res = {w_a[6:0], 1'b0};
        w_c   = w_a[7];
      end
      c_op_sra: begin
        w_res = {w_a[7], w_a[7:1]};
        w_c   = w_a[0];
      end
      c_op_srl: begin
        w_res = {1'b0, w_a[7:1]};
        w_c   = w_a[0];
      end
      c_op_swap: begin
        w_res = {w_a[3:0], w_a[7:4]};
        w_c   = 1'b0;
      end
      c_op_bit: begin
        w_z_from_res = 1'b0;
        w_z_raw      = ~w_a[w_b[2:0]];
        w_h          = 1'b1;
      end
      c_op_res: begin
        w_res        = w_a & ~w_mask;
        w_z_from_res = 1'b0;
      end
      c_op_set: begin
        w_res        = w_a | w_mask;
        w_z_from_res = 1'b0;
      end
      default: begin
        // Unused opcodes: pass A through, only C survives.
        w_z_from_res = 1'b0;
      end
    endcase
    w_z     = w_z_from_res ? (w_res == 8'h00) : w_z_raw;
    w_flags = {w_z, w_n, w_h, w_c, 4'b0000};
  end

`ifdef ALU8_OUTREG_EN
  logic [7:0] res_d;
  logic [7:0] res_q;
  logic [7:0] flags_out_d;
  logic [7:0] flags_out_q;

  // Output stage inputs: always the fresh combinational result.
  always_comb begin
    res_d       = w_res;
    flags_out_d = w_flags;
  end

  // Output stage registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q       <= 8'h00;
      flags_out_q <= 8'h00;
    end else begin
      res_q       <= res_d;
      flags_out_q <= flags_out_d;
    end
  end

  assign bus.res      = res_q;
  assign bus.flagsOut = flags_out_q;
  assign w_flags_src  = flags_out_q;
`else
  assign bus.res      = w_res;
  assign bus.flagsOut = w_flags;
  assign w_flags_src  = w_flags;
`endif

  // Flags shadow next value: load on write enable, otherwise hold.
  always_comb begin
    flags_reg_d = flags_reg_q;
    if (bus.flagsWe) begin
      flags_reg_d = w_flags_src;
    end
  end

  // Flags shadow register; reset wins over the write enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg_q <= 8'h00;
    end else begin
      flags_reg_q <= flags_reg_d;
    end
  end

  assign bus.flagsQ = flags_reg_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_8
// Description : Self-checking bench for alu_8. Expected results are queued
//               when stimulus is applied and popped when the DUT output is
//               sampled. Honours ALU8_OUTREG_EN (extra cycle of latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_8;

`ifdef ALU8_OUTREG_EN
  localparam int c_lat = 1;
`else
  localparam int c_lat = 0;
`endif

  typedef struct {
    logic [7:0] res;
    logic [7:0] flags;
  } exp_t;

  typedef struct {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic [7:0] flags;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  logic [7:0] fq[$];

  alu_8_if bus ();

  alu_8 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Independent integer reference model; returns {res, flags}.
  function automatic logic [15:0] ref_alu(input logic [4:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic cin);
    int ai, bi, cv, ci, r, idx;
    bit z, n, h, c, zr, zb;
    ai = int'(a); bi = int'(b); cv = cin ? 1 : 0; ci = 0;
    idx = bi % 8;
    r = ai; n = 0; h = 0; c = cin; zr = 1; zb = 0;
    case (op)
      5'd0, 5'd1: begin
        if (op == 5'd1) ci = cv;
        r = ai + bi + ci; h = ((ai % 16) + (bi % 16) + ci) > 15; c = (r > 255);
      end
      5'd2, 5'd3, 5'd4: begin
        if (op == 5'd3) ci = cv;
        r = ai - bi - ci; n = 1; h = ((ai % 16) - (bi % 16) - ci) < 0; c = (r < 0);
      end
      5'd5: begin r = ai & bi; h = 1; c = 0; end
      5'd6: begin r = ai | bi; c = 0; end
      5'd7: begin r = ai ^ bi; c = 0; end
      5'd8, 5'd10: begin r = ((ai * 2) % 256) + cv; c = (ai >= 128); zr = (op == 5'd8); end
      5'd9, 5'd11: begin r = (ai / 2) + cv * 128; c = (ai % 2) == 1; zr = (op == 5'd9); end
      5'd12, 5'd14: begin r = ((ai * 2) % 256) + ai / 128; c = (ai >= 128); zr = (op == 5'd12); end
      5'd13, 5'd15: begin r = (ai / 2) + (ai % 2) * 128; c = (ai % 2) == 1; zr = (op == 5'd13); end
      5'd16: begin r = (ai * 2) % 256; c = (ai >= 128); end
      5'd17: begin r = (ai / 2) + (ai >= 128 ? 128 : 0); c = (ai % 2) == 1; end
      5'd18: begin r = ai / 2; c = (ai % 2) == 1; end
      5'd19: begin r = (ai % 16) * 16 + ai / 16; c = 0; end
      5'd20: begin zr = 0; zb = ((ai >> idx) % 2) == 0; h = 1; end
      5'd21: begin r = ((ai >> idx) % 2 == 1) ? ai - (1 << idx) : ai; zr = 0; end
      5'd22: begin r = ((ai >> idx) % 2 == 0) ? ai + (1 << idx) : ai; zr = 0; end
      default: begin zr = 0; end
    endcase
    r = r & 255;
    z = zr ? (r == 0) : zb;
    if (op == 5'd4) r = ai;
    return {8'(r), z, n, h, c, 4'b0000};
  endfunction

  task automatic drive(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic we);
    bus.opcode  = op;
    bus.regA    = a;
    bus.regB    = b;
    bus.carryIn = cin;
    bus.flagsWe = we;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(5'd0, 8'h3A, 8'hC6, 1'b0, 1'b1);
    fq.push_back(8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.flagsQ !== fq[0]) begin
      n_errors++;
      $display("FAIL reset_flagsQ: got %h expected %h", bus.flagsQ, fq[0]);
    end
    void'(fq.pop_front());
`ifdef ALU8_OUTREG_EN
    n_checks++;
    if (bus.res !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_res: got %h expected 00", bus.res);
    end
`endif
    reset = 1'b0;
    bus.flagsWe = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[$];
    exp_t e;
    v.push_back('{5'd0,  8'h3A, 8'hC6, 1'b0, 8'h00, 8'hB0});
    v.push_back('{5'd1,  8'h0F, 8'h00, 1'b1, 8'h10, 8'h20});
    v.push_back('{5'd3,  8'h00, 8'h01, 1'b1, 8'hFE, 8'h70});
    v.push_back('{5'd4,  8'h3E, 8'h3E, 1'b0, 8'h3E, 8'hC0});
    v.push_back('{5'd8,  8'h80, 8'h00, 1'b0, 8'h00, 8'h90});
    v.push_back('{5'd10, 8'h80, 8'h00, 1'b0, 8'h00, 8'h10});
    v.push_back('{5'd13, 8'h01, 8'h00, 1'b0, 8'h80, 8'h10});
    v.push_back('{5'd17, 8'h8A, 8'h00, 1'b0, 8'hC5, 8'h00});
    v.push_back('{5'd19, 8'hF0, 8'h00, 1'b0, 8'h0F, 8'h00});
    v.push_back('{5'd5,  8'hF0, 8'h0F, 1'b0, 8'h00, 8'hA0});
    v.push_back('{5'd20, 8'hEF, 8'h04, 1'b1, 8'hEF, 8'hB0});
    v.push_back('{5'd22, 8'h00, 8'h07, 1'b0, 8'h80, 8'h00});
    v.push_back('{5'd21, 8'hFF, 8'h00, 1'b0, 8'hFE, 8'h00});
    v.push_back('{5'd22, 8'h00, 8'hFB, 1'b1, 8'h08, 8'h10});
    v.push_back('{5'd31, 8'h00, 8'h55, 1'b1, 8'h00, 8'h10});
    foreach (v[i]) begin
      @(posedge clk);
      #1;
      drive(v[i].op, v[i].a, v[i].b, v[i].cin, 1'b0);
      sb.push_back('{v[i].res, v[i].flags});
      repeat (c_lat) @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (bus.res !== e.res) begin
        n_errors++;
        $display("FAIL dir%0d_res op=%h: got %h expected %h", i, v[i].op, bus.res, e.res);
      end
      n_checks++;
      if (bus.flagsOut !== e.flags) begin
        n_errors++;
        $display("FAIL dir%0d_flags op=%h: got %h expected %h", i, v[i].op, bus.flagsOut, e.flags);
      end
    end
  endtask

  task automatic test_flags_reg();
    // Load: ADD with write enable.
    @(posedge clk);
    #1;
    drive(5'd0, 8'h3A, 8'hC6, 1'b0, 1'b1);
    fq.push_back(8'hB0);
    repeat (c_lat + 1) @(posedge clk);
    #1;
    // Hold: different flags on the bus, write enable low.
    drive(5'd5, 8'hF0, 8'h0F, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.flagsQ !== fq[0]) begin
      n_errors++;
      $display("FAIL flagsQ_load: got %h expected %h", bus.flagsQ, fq[0]);
    end
    repeat (c_lat + 2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.flagsQ !== fq[0]) begin
      n_errors++;
      $display("FAIL flagsQ_hold: got %h expected %h", bus.flagsQ, fq[0]);
    end
    void'(fq.pop_front());
    // Reset beats write enable.
    drive(5'd0, 8'h3A, 8'hC6, 1'b0, 1'b1);
    reset = 1'b1;
    fq.push_back(8'h00);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.flagsQ !== fq[0]) begin
      n_errors++;
      $display("FAIL flagsQ_reset_wins: got %h expected %h", bus.flagsQ, fq[0]);
    end
    void'(fq.pop_front());
    reset = 1'b0;
    bus.flagsWe = 1'b0;
    @(posedge clk);
  endtask

  // Back-to-back stream, one operation per cycle, flags written every cycle.
  task automatic test_random_stream();
    logic [15:0] r;
    logic [7:0]  a, b, fe;
    logic        cin;
    exp_t        e;
    sb.delete();
    fq.delete();
    for (int op = 0; op < 32; op++) begin
      for (int k = 0; k < 100; k++) begin
        @(posedge clk);
        #1;
        a   = 8'($urandom);
        b   = 8'($urandom);
        cin = 1'($urandom);
        drive(5'(op), a, b, cin, 1'b1);
        r = ref_alu(5'(op), a, b, cin);
        sb.push_back('{r[15:8], r[7:0]});
        fq.push_back(r[7:0]);
        @(negedge clk);
        if (sb.size() > c_lat) begin
          e = sb.pop_front();
          n_checks++;
          if (bus.res !== e.res) begin
            n_errors++;
            $display("FAIL rnd_res op=%0d k=%0d: got %h expected %h", op, k, bus.res, e.res);
          end
          n_checks++;
          if (bus.flagsOut !== e.flags) begin
            n_errors++;
            $display("FAIL rnd_flags op=%0d k=%0d: got %h expected %h", op, k, bus.flagsOut, e.flags);
          end
        end
        if (fq.size() > c_lat + 1) begin
          fe = fq.pop_front();
          n_checks++;
          if (bus.flagsQ !== fe) begin
            n_errors++;
            $display("FAIL rnd_flagsQ op=%0d k=%0d: got %h expected %h", op, k, bus.flagsQ, fe);
          end
        end
      end
    end
    bus.flagsWe = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(5'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    test_reset();
    test_directed();
    test_flags_reg();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
